regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//   Parametrised multi-port integer register file with a built-in write scoreboard.
//   Next-generation register file for the RISC-V cores, scalable to multi-issue.
//   Provides NRD asynchronous read ports and NWR synchronous write ports.
//   Tracks one busy bit per register (pending writeback), issues/blocks destinations,
//   and reports operand-busy status to the decode stage.
// PARAMETERS
//   XLEN   32  data width of each register
//   NREGS  32  number of architectural registers (power of 2, >=2); AW = $clog2(NREGS)
//   NRD    2   number of read ports
//   NWR    1   number of write ports (writeback lanes)
// PORTS
//   clk        in   1          clock, rising edge
//   rst        in   1          synchronous reset, active-high
//   rd_addr    in   NRD*AW     read addresses, port p at [p*AW +: AW]
//   rd_data    out  NRD*XLEN   read data, port p at [p*XLEN +: XLEN]
//   rd_busy    out  NRD        1 = register at rd_addr[p] has a pending write
//   wr_en      in   NWR        writeback strobe per lane
//   wr_addr    in   NWR*AW     writeback destination per lane
//   wr_data    in   NWR*XLEN   writeback data per lane
//   iss_valid  in   1          decode requests to claim destination iss_rd
//   iss_rd     in   AW         destination register being claimed
//   iss_ready  out  1          claim accepted this cycle (iss_valid && iss_ready = fire)
//   busy_cnt   out  AW+1       number of registers currently busy
// BEHAVIOUR
//   - Reset (rst=1 at posedge): all registers <= 0, all busy bits <= 0, busy_cnt = 0.
//     Reset overrides any write or issue in the same cycle; rd_data then reads 0.
//   - Register 0 hardwired: reads 0, writes ignored, never busy, iss_rd=0 always ready
//     and sets nothing.
//   - Reads: combinational, zero latency; rd_data[p] = mem[rd_addr[p]] (see CONFIG).
//   - Writes: at posedge, for each lane with wr_en && wr_addr!=0, mem <= wr_data.
//     Same address on several lanes in one cycle: highest lane index wins.
//   - Scoreboard:
//       iss_ready = !busy[iss_rd] (combinational; 1 for iss_rd=0), independent of iss_valid.
//       fire sets busy[iss_rd] at next posedge (WAW blocked while pending).
//       wr_en on lane k clears busy[wr_addr[k]] at posedge.
//       Same-cycle clear by writeback and set by fire on the same register:
//       set wins (new pending write).
//       Writeback to a non-busy register is legal: data written, busy stays 0.
//   - busy_cnt: registered popcount of busy bits, updated with them, never exceeds NREGS-1.
//   - No other state; no FSM beyond per-register busy flags.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     rd_data[p] returns wr_data of the highest-index lane writing rd_addr[p] this cycle
//     (addr!=0), and rd_busy[p] = 0 for that register (write-through forwarding, 0 cycles).
//   REGFILE_BYPASS_EN undefined:
//     rd_data shows the old value until the edge; rd_busy reflects the stored busy bit only.
// TESTING
//   1 rst=1 one cycle after random writes -> all reads 0, busy_cnt=0, iss_ready=1.
//   2 wr_en=1 addr=0 data=32'hDEADBEEF -> read x0 = 0; fire iss_rd=0 -> busy_cnt stays 0.
//   3 fire iss_rd=5; next cycle iss_rd=5 -> iss_ready=0, rd_busy=1 on port reading x5,
//     busy_cnt=1; wr x5=32'h1234 -> next cycle busy clear, read 32'h1234.
//   4 NWR=2, both lanes write x7 (A, then B on lane1) -> x7=B; same cycle fire iss_rd=7
//     while x7 clear -> x7 busy.
//   5 BYPASS_EN: read x9 while writing x9=32'hCAFE -> same-cycle rd_data=32'hCAFE, rd_busy=0;
//     without macro -> old value, busy as stored.
//   6 Claim all x1..x31 -> busy_cnt=31; rst mid-sequence with wr_en=1 -> all cleared.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-port integer register file with per-register pending-write scoreboard.
// Optional same-cycle write-through forwarding on reads: define REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NRD*$clog2(NREGS)-1:0]      rd_addr,
  output logic [NRD*XLEN-1:0]               rd_data,
  output logic [NRD-1:0]                    rd_busy,
  input  logic [NWR-1:0]                    wr_en,
  input  logic [NWR*$clog2(NREGS)-1:0]      wr_addr,
  input  logic [NWR*XLEN-1:0]               wr_data,
  input  logic                              iss_valid,
  input  logic [$clog2(NREGS)-1:0]          iss_rd,
  output logic                              iss_ready,
  output logic [$clog2(NREGS):0]            busy_cnt
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW:0]      busy_cnt_q;
  logic [AW:0]      busy_cnt_d;
  logic             fire;

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // x0 is never busy, so a claim of x0 is always accepted and sets nothing
  assign iss_ready = !busy_q[iss_rd];
  assign fire      = iss_valid && iss_ready;
  assign busy_cnt  = busy_cnt_q;

  always_comb begin
    mem_d = mem_q;
    // ascending lane order makes the highest lane win on address collisions
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k] && (wr_addr[k*AW +: AW] != '0)) begin
        mem_d[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
      end
    end
    mem_d[0] = '0;
  end

  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k]) begin
        busy_d[wr_addr[k*AW +: AW]] = 1'b0;
      end
    end
    // a new claim is applied after the writeback clears so the set wins
    if (fire) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0]  = 1'b0;
    busy_cnt_d = popcount(busy_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_data[p*XLEN +: XLEN] = mem_q[rd_addr[p*AW +: AW]];
      rd_busy[p]              = busy_q[rd_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] == rd_addr[p*AW +: AW]) &&
            (rd_addr[p*AW +: AW] != '0)) begin
          rd_data[p*XLEN +: XLEN] = wr_data[k*XLEN +: XLEN];
          rd_busy[p]              = 1'b0;
        end
      end
`else
      ;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (NRD=2, NWR=2) with immediate assertions.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic                 iss_ready;
  logic [AW:0]          busy_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .iss_ready(iss_ready), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; iss_valid = 1'b0; iss_rd = '0;
  endtask

  task automatic wr(input logic [1:0] en, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                    input logic [AW-1:0] a0, input logic [XLEN-1:0] d0);
    wr_en = en; wr_addr = {a1, a0}; wr_data = {d1, d0};
  endtask

  logic bypass;

  initial begin
`ifdef REGFILE_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    rst = 1'b1; rd_addr = '0; idle();
    tick();

    // 1: writes and a claim, then reset with traffic still driven
    rst = 1'b0;
    wr(2'b11, 5'd4, 32'h2222, 5'd3, 32'h1111);
    iss_valid = 1'b1; iss_rd = 5'd6;
    tick();
    rst = 1'b1;
    wr(2'b11, 5'd4, 32'h4444, 5'd3, 32'h3333);
    iss_valid = 1'b1; iss_rd = 5'd10;
    tick();
    rst = 1'b0; idle(); iss_rd = 5'd6; rd_addr = {5'd4, 5'd3};
    #1;
    chk("rst_x3", {32'd0, rd_data[31:0]}, 64'd0);
    chk("rst_x4", {32'd0, rd_data[63:32]}, 64'd0);
    chk("rst_cnt", {58'd0, busy_cnt}, 64'd0);
    chk("rst_ready", {63'd0, iss_ready}, 64'd1);
    chk("rst_busy", {62'd0, rd_busy}, 64'd0);

    // 2: x0 hardwired
    wr(2'b01, 5'd0, 32'd0, 5'd0, 32'hDEADBEEF);
    iss_valid = 1'b1; iss_rd = 5'd0; rd_addr = {5'd0, 5'd0};
    #1;
    chk("x0_ready", {63'd0, iss_ready}, 64'd1);
    chk("x0_fwd", {32'd0, rd_data[31:0]}, 64'd0);
    tick();
    idle();
    #1;
    chk("x0_read", {32'd0, rd_data[31:0]}, 64'd0);
    chk("x0_cnt", {58'd0, busy_cnt}, 64'd0);

    // 3: claim x5, then writeback
    iss_valid = 1'b1; iss_rd = 5'd5;
    #1;
    chk("x5_ready0", {63'd0, iss_ready}, 64'd1);
    tick();
    idle(); iss_rd = 5'd5; rd_addr = {5'd5, 5'd0};
    #1;
    chk("x5_ready1", {63'd0, iss_ready}, 64'd0);
    chk("x5_rdbusy", {62'd0, rd_busy}, 64'd2);
    chk("x5_cnt", {58'd0, busy_cnt}, 64'd1);
    wr(2'b01, 5'd0, 32'd0, 5'd5, 32'h1234);
    #1;
    chk("x5_wr_data", {32'd0, rd_data[63:32]}, bypass ? 64'h1234 : 64'd0);
    chk("x5_wr_busy", {62'd0, rd_busy}, bypass ? 64'd0 : 64'd2);
    tick();
    idle(); iss_rd = 5'd5;
    #1;
    chk("x5_after_data", {32'd0, rd_data[63:32]}, 64'h1234);
    chk("x5_after_busy", {62'd0, rd_busy}, 64'd0);
    chk("x5_after_cnt", {58'd0, busy_cnt}, 64'd0);
    chk("x5_after_ready", {63'd0, iss_ready}, 64'd1);

    // 4: two lanes on x7 (lane1 wins) plus claim of x7 in the same cycle
    wr(2'b11, 5'd7, 32'hBBBB, 5'd7, 32'hAAAA);
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    chk("x7_ready", {63'd0, iss_ready}, 64'd1);
    tick();
    idle(); iss_rd = 5'd7; rd_addr = {5'd8, 5'd7};
    #1;
    chk("x7_data", {32'd0, rd_data[31:0]}, 64'hBBBB);
    chk("x7_busy", {62'd0, rd_busy}, 64'd1);
    chk("x7_cnt", {58'd0, busy_cnt}, 64'd1);
    chk("x7_blocked", {63'd0, iss_ready}, 64'd0);
    // writeback clears x7; x8 is written while not busy
    wr(2'b11, 5'd8, 32'hDDDD, 5'd7, 32'hCCCC);
    tick();
    idle();
    #1;
    chk("x7_c", {32'd0, rd_data[31:0]}, 64'hCCCC);
    chk("x8_d", {32'd0, rd_data[63:32]}, 64'hDDDD);
    chk("x78_cnt", {58'd0, busy_cnt}, 64'd0);
    chk("x78_busy", {62'd0, rd_busy}, 64'd0);

    // 5: forwarding of x9 while busy
    wr(2'b01, 5'd0, 32'd0, 5'd9, 32'h55);
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    idle(); rd_addr = {5'd0, 5'd9};
    #1;
    chk("x9_old", {32'd0, rd_data[31:0]}, 64'h55);
    chk("x9_cnt", {58'd0, busy_cnt}, 64'd1);
    wr(2'b10, 5'd9, 32'hCAFE, 5'd0, 32'd0);
    #1;
    chk("x9_fwd_data", {32'd0, rd_data[31:0]}, bypass ? 64'hCAFE : 64'h55);
    chk("x9_fwd_busy", {62'd0, rd_busy}, bypass ? 64'd0 : 64'd1);
    tick();
    idle();
    #1;
    chk("x9_new", {32'd0, rd_data[31:0]}, 64'hCAFE);
    chk("x9_clr", {62'd0, rd_busy}, 64'd0);

    // 6: claim every register, then reset with a write pending
    for (int r = 1; r < NREGS; r++) begin
      iss_valid = 1'b1; iss_rd = AW'(r);
      tick();
      if (r == 16) chk("claim16_cnt", {58'd0, busy_cnt}, 64'd16);
    end
    idle(); iss_rd = 5'd20; rd_addr = {5'd31, 5'd1};
    #1;
    chk("claim_all_cnt", {58'd0, busy_cnt}, 64'd31);
    chk("claim_all_ready", {63'd0, iss_ready}, 64'd0);
    chk("claim_all_busy", {62'd0, rd_busy}, 64'd3);
    rst = 1'b1;
    wr(2'b01, 5'd0, 32'd0, 5'd12, 32'hABC);
    tick();
    rst = 1'b0; idle(); iss_rd = 5'd20; rd_addr = {5'd12, 5'd7};
    #1;
    chk("final_cnt", {58'd0, busy_cnt}, 64'd0);
    chk("final_ready", {63'd0, iss_ready}, 64'd1);
    chk("final_busy", {62'd0, rd_busy}, 64'd0);
    chk("final_x7", {32'd0, rd_data[31:0]}, 64'd0);
    chk("final_x12", {32'd0, rd_data[63:32]}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
